// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encodings
// and the halt-drain defaults.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // EX, MEM and WB must retire the halting ecall before the core reports halted.
  localparam int DRAIN_CYCLES_DEF = 3;
  // a7 (x17) value that marks the terminating ecall.
  localparam int HALT_ECALL_X17   = 10;

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Free-running performance counter with synchronous active-low clear and
// increment enable; wraps modulo 2^CNT_W.
module pipeline_stall_ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush responder for the 5-stage pipeline: arbitrates D-cache stalls,
// mispredict flushes, load-use bubbles, I-cache misses and the halt drain.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             is_hazard,
  input  logic             ex_mispredict,
  input  logic             is_halt_id,
  input  logic             icache_ready,
  input  logic             dcache_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             r_state;
  state_e             w_next_state;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_next_drain_cnt;
  logic               r_is_halted;
  logic               w_flush_inc;
  logic               w_stall_inc;

  always_comb begin
    // NOTE: all outputs get a default first so no branch of the case infers a latch.
    pc_write         = 1'b0;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    pipe_hold        = 1'b0;
    w_flush_inc      = 1'b0;
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;

    if (!reset_n) begin
      // Keep NOPs/bubbles flowing while reset is held.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!dcache_ready) begin
            // EX is frozen too, so a pending mispredict is re-presented later.
            pipe_hold = 1'b1;
          end else if (ex_mispredict) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flush_inc = 1'b1;
          end else if (is_hazard) begin
            id_ex_flush = 1'b1;
          end else if (is_halt_id) begin
            if_id_write      = 1'b1;
            if_id_flush      = 1'b1;
            w_next_state     = ST_DRAIN;
            w_next_drain_cnt = DRAIN_W'(DRAIN_CYCLES - 1);
          end else if (!icache_ready) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end

        ST_DRAIN: begin
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          if (!dcache_ready) begin
            pipe_hold = 1'b1;
          end else if (r_drain_cnt == '0) begin
            w_next_state = ST_HALTED;
          end else begin
            w_next_drain_cnt = r_drain_cnt - DRAIN_W'(1);
          end
        end

        ST_HALTED: begin
          pipe_hold = 1'b1;
        end

        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_is_halted <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
      r_is_halted <= (w_next_state == ST_HALTED);
    end
  end

  assign is_halted   = r_is_halted;
  assign w_stall_inc = (r_state != ST_HALTED) && !pc_write;

  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clr_n (reset_n),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clr_n (reset_n),
    .i_inc   (w_flush_inc),
    .o_count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; a second 4-bit-counter instance
// shares the stimulus so counter wrap is reachable in a few cycles.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, is_hazard, ex_mispredict, is_halt_id, icache_ready, dcache_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, is_halted;
  logic [31:0] stall_cycles, flush_events;
  logic        n_pc_write, n_if_id_write, n_if_id_flush, n_id_ex_flush, n_pipe_hold, n_is_halted;
  logic [3:0]  n_stall_cycles, n_flush_events;

  int n_cmp = 0;
  int n_err = 0;

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  localparam logic [4:0] CTL_RUN    = 5'b11000;
  localparam logic [4:0] CTL_RST    = 5'b00110;
  localparam logic [4:0] CTL_DSTALL = 5'b00001;
  localparam logic [4:0] CTL_MISP   = 5'b11110;
  localparam logic [4:0] CTL_HAZ    = 5'b00010;
  localparam logic [4:0] CTL_ICMISS = 5'b01100;
  localparam logic [4:0] CTL_HALTED = 5'b00001;
  localparam logic [4:0] CTL_DRAIN  = 5'b00100;
  localparam logic [4:0] CTL_DRAINH = 5'b00101;
  localparam logic [4:0] M_ALL      = 5'b11111;
  localparam logic [4:0] M_DRAIN    = 5'b10101;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .is_hazard     (is_hazard),
    .ex_mispredict (ex_mispredict),
    .is_halt_id    (is_halt_id),
    .icache_ready  (icache_ready),
    .dcache_ready  (dcache_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .pipe_hold     (pipe_hold),
    .is_halted     (is_halted),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
  );

  pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_n (
    .clk           (clk),
    .reset_n       (reset_n),
    .is_hazard     (is_hazard),
    .ex_mispredict (ex_mispredict),
    .is_halt_id    (is_halt_id),
    .icache_ready  (icache_ready),
    .dcache_ready  (dcache_ready),
    .pc_write      (n_pc_write),
    .if_id_write   (n_if_id_write),
    .if_id_flush   (n_if_id_flush),
    .id_ex_flush   (n_id_ex_flush),
    .pipe_hold     (n_pipe_hold),
    .is_halted     (n_is_halted),
    .stall_cycles  (n_stall_cycles),
    .flush_events  (n_flush_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs just after the edge, check the combinational
  // controls mid-cycle, then advance to 1 ns past the next rising edge.
  task automatic cyc(input logic rst, input logic haz, input logic misp, input logic halt,
                     input logic ic, input logic dc,
                     input logic [4:0] exp_ctl, input logic [4:0] mask, input string tag);
    logic [4:0] ctl;
    reset_n       = rst;
    is_hazard     = haz;
    ex_mispredict = misp;
    is_halt_id    = halt;
    icache_ready  = ic;
    dcache_ready  = dc;
    #4;
    ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};
    check(tag, 32'(ctl & mask), 32'(exp_ctl & mask));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; is_hazard = 1'b0; ex_mispredict = 1'b0;
    is_halt_id = 1'b0; icache_ready = 1'b1; dcache_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset, then idle
    cyc(0, 0, 0, 0, 1, 1, CTL_RST, M_ALL, "reset_ctl_0");
    cyc(0, 0, 0, 0, 1, 1, CTL_RST, M_ALL, "reset_ctl_1");
    check("reset_stall_cnt", stall_cycles, 32'd0);
    check("reset_flush_cnt", flush_events, 32'd0);
    check("reset_halted", 32'(is_halted), 32'd0);
    cyc(1, 0, 0, 0, 1, 1, CTL_RUN, M_ALL, "idle_ctl");
    check("idle_stall_cnt", stall_cycles, 32'd0);

    // Load-use bubble
    cyc(1, 1, 0, 0, 1, 1, CTL_HAZ, M_ALL, "hazard_ctl");
    check("hazard_stall_cnt", stall_cycles, 32'd1);

    // Mispredict wins over a simultaneous hazard
    cyc(1, 1, 1, 0, 1, 1, CTL_MISP, M_ALL, "misp_haz_ctl");
    check("misp_flush_cnt", flush_events, 32'd1);
    check("misp_stall_cnt", stall_cycles, 32'd1);

    // D-cache stall overrides a held mispredict for 3 cycles
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1, 0, CTL_DSTALL, M_ALL, "dstall_ctl");
    check("dstall_stall_cnt", stall_cycles, 32'd4);
    check("dstall_flush_cnt", flush_events, 32'd1);
    cyc(1, 0, 1, 0, 1, 1, CTL_MISP, M_ALL, "dstall_release_ctl");
    check("dstall_release_flush", flush_events, 32'd2);

    // I-cache miss
    cyc(1, 0, 0, 0, 0, 1, CTL_ICMISS, M_ALL, "icmiss_ctl");
    check("icmiss_stall_cnt", stall_cycles, 32'd5);

    // Counter wrap on the 4-bit instance: 15 -> 0, the 32-bit one keeps going
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1, 1, CTL_HAZ, M_ALL, "wrap_haz_ctl");
    check("wrap_pre_narrow", 32'(n_stall_cycles), 32'hF);
    cyc(1, 1, 0, 0, 1, 1, CTL_HAZ, M_ALL, "wrap_last_ctl");
    check("wrap_narrow", 32'(n_stall_cycles), 32'h0);
    check("wrap_wide", stall_cycles, 32'd16);
    check("wrap_narrow_flush", 32'(n_flush_events), 32'd2);

    // Halt drain with no D-stall; hazard/mispredict/icache ignored in DRAIN
    cyc(1, 0, 0, 1, 1, 1, CTL_DRAIN, M_DRAIN, "halt_accept_ctl");
    check("halt_accept_halted", 32'(is_halted), 32'd0);
    cyc(1, 1, 1, 0, 0, 1, CTL_DRAIN, M_DRAIN, "drain0_ctl");
    check("drain0_halted", 32'(is_halted), 32'd0);
    cyc(1, 1, 1, 0, 0, 1, CTL_DRAIN, M_DRAIN, "drain1_ctl");
    check("drain1_halted", 32'(is_halted), 32'd0);
    cyc(1, 0, 0, 0, 1, 1, CTL_DRAIN, M_DRAIN, "drain2_ctl");
    check("drain_done_halted", 32'(is_halted), 32'd1);
    check("drain_flush_cnt", flush_events, 32'd2);
    check("drain_stall_cnt", stall_cycles, 32'd20);

    // HALTED holds and does not count stalls
    cyc(1, 0, 1, 0, 1, 1, CTL_HALTED, M_ALL, "halted_ctl_0");
    cyc(1, 1, 0, 0, 1, 1, CTL_HALTED, M_ALL, "halted_ctl_1");
    check("halted_stall_cnt", stall_cycles, 32'd20);
    check("halted_flush_cnt", flush_events, 32'd2);
    check("halted_sticky", 32'(is_halted), 32'd1);

    // Reset out of HALTED
    cyc(0, 0, 0, 0, 1, 1, CTL_RST, M_ALL, "rst_from_halted_ctl");
    check("rst_from_halted", 32'(is_halted), 32'd0);
    check("rst_clears_stall", stall_cycles, 32'd0);

    // Halt drain with 2 D-stall cycles: halted 2 edges later
    cyc(1, 0, 0, 1, 1, 1, CTL_DRAIN, M_DRAIN, "halt2_accept_ctl");
    cyc(1, 0, 0, 0, 1, 0, CTL_DRAINH, M_DRAIN, "halt2_dstall0_ctl");
    cyc(1, 0, 0, 0, 1, 0, CTL_DRAINH, M_DRAIN, "halt2_dstall1_ctl");
    check("halt2_frozen_halted", 32'(is_halted), 32'd0);
    cyc(1, 0, 0, 0, 1, 1, CTL_DRAIN, M_DRAIN, "halt2_drain0_ctl");
    cyc(1, 0, 0, 0, 1, 1, CTL_DRAIN, M_DRAIN, "halt2_drain1_ctl");
    check("halt2_not_yet", 32'(is_halted), 32'd0);
    cyc(1, 0, 0, 0, 1, 1, CTL_DRAIN, M_DRAIN, "halt2_drain2_ctl");
    check("halt2_halted", 32'(is_halted), 32'd1);
    check("halt2_stall_cnt", stall_cycles, 32'd6);

    // Reset in the middle of DRAIN, with D-cache busy: no residual hold
    cyc(0, 0, 0, 0, 1, 1, CTL_RST, M_ALL, "pre_middrain_rst");
    cyc(1, 0, 0, 1, 1, 1, CTL_DRAIN, M_DRAIN, "middrain_accept_ctl");
    cyc(1, 0, 0, 0, 1, 1, CTL_DRAIN, M_DRAIN, "middrain_drain0_ctl");
    cyc(0, 0, 0, 0, 1, 0, CTL_RST, M_ALL, "middrain_rst_ctl");
    check("middrain_rst_halted", 32'(is_halted), 32'd0);
    cyc(1, 0, 0, 0, 1, 1, CTL_RUN, M_ALL, "middrain_run_ctl");
    check("middrain_run_stall", stall_cycles, 32'd0);
    check("middrain_run_halted", 32'(is_halted), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
